// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one result bit per clock, LSB first.
//
// Ports:
//   i_clk        rising-edge clock
//   i_clear_n    synchronous active-low clear
//   i_start      begin an operation (sampled only while idle)
//   i_mode       0 = a+b, 1 = a-b (captured with start)
//   i_a, i_b     W-bit operands (captured with start)
//   o_busy       high whenever not idle
//   o_sum_bit    registered serial result bit
//   o_sum_valid  high while o_sum_bit carries a result bit
//   o_done       one-cycle pulse; o_result/o_cout/o_ovf valid
//   o_result     parallel result, held until the next completed operation
//   o_cout       final carry out (subtract: 1 = no borrow)
//   o_ovf        signed two's-complement overflow
module serial_addsub #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_clear_n,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_sum_bit,
    output logic         o_sum_valid,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_cout,
    output logic         o_ovf
);

    // Counter only ever reaches W-1; sized for W+1 values so it cannot wrap.
    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          r_state,     w_state_next;
    logic [W-1:0]    r_sa,        w_sa_next;
    logic [W-1:0]    r_sb,        w_sb_next;
    logic [W-1:0]    r_sum,       w_sum_next;
    logic [W-1:0]    r_result,    w_result_next;
    logic [CntW-1:0] r_cnt,       w_cnt_next;
    logic            r_carry,     w_carry_next;
    logic            r_sum_bit,   w_sum_bit_next;
    logic            r_sum_valid, w_sum_valid_next;
    logic            r_cout,      w_cout_next;
    logic            r_ovf,       w_ovf_next;

    logic w_s;
    logic w_c;

    // One full-adder slice on the current LSBs.
    assign w_s = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_c = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

    always_ff @(posedge i_clk) begin
        if (!i_clear_n) begin
            r_state     <= StIdle;
            r_sa        <= '0;
            r_sb        <= '0;
            r_sum       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sum_bit   <= 1'b0;
            r_sum_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sa        <= w_sa_next;
            r_sb        <= w_sb_next;
            r_sum       <= w_sum_next;
            r_result    <= w_result_next;
            r_cnt       <= w_cnt_next;
            r_carry     <= w_carry_next;
            r_sum_bit   <= w_sum_bit_next;
            r_sum_valid <= w_sum_valid_next;
            r_cout      <= w_cout_next;
            r_ovf       <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sa_next        = r_sa;
        w_sb_next        = r_sb;
        w_sum_next       = r_sum;
        w_result_next    = r_result;
        w_cnt_next       = r_cnt;
        w_carry_next     = r_carry;
        w_sum_bit_next   = 1'b0;
        w_sum_valid_next = 1'b0;
        w_cout_next      = r_cout;
        w_ovf_next       = r_ovf;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                    w_sa_next    = i_a;
                    // Subtract as a + ~b + 1: the +1 enters as the initial carry.
                    w_sb_next    = i_mode ? ~i_b : i_b;
                    w_carry_next = i_mode;
                    w_cnt_next   = '0;
                end
            end
            StRun: begin
                w_sa_next        = r_sa >> 1;
                w_sb_next        = r_sb >> 1;
                w_carry_next     = w_c;
                w_sum_next       = {w_s, r_sum[W-1:1]};
                w_sum_bit_next   = w_s;
                w_sum_valid_next = 1'b1;
                if (r_cnt == LastCnt) begin
                    w_state_next  = StDone;
                    w_result_next = {w_s, r_sum[W-1:1]};
                    w_cout_next   = w_c;
                    // r_carry here is the carry into the MSB.
                    w_ovf_next    = r_carry ^ w_c;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_sum_bit   = r_sum_bit;
    assign o_sum_valid = r_sum_valid;
    assign o_result    = r_result;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at W = 8, 16 and 2.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear_n;
    logic        mode;
    logic        start8, start16, start2;
    logic [15:0] a, b;

    logic        busy8, sbit8, sval8, done8, cout8, ovf8;
    logic [7:0]  res8;
    logic        busy16, sbit16, sval16, done16, cout16, ovf16;
    logic [15:0] res16;
    logic        busy2, sbit2, sval2, done2, cout2, ovf2;
    logic [1:0]  res2;

    serial_addsub #(.W(8)) u_dut8 (
        .i_clk(clk), .i_clear_n(clear_n), .i_start(start8), .i_mode(mode),
        .i_a(a[7:0]), .i_b(b[7:0]), .o_busy(busy8), .o_sum_bit(sbit8),
        .o_sum_valid(sval8), .o_done(done8), .o_result(res8), .o_cout(cout8), .o_ovf(ovf8)
    );

    serial_addsub #(.W(16)) u_dut16 (
        .i_clk(clk), .i_clear_n(clear_n), .i_start(start16), .i_mode(mode),
        .i_a(a), .i_b(b), .o_busy(busy16), .o_sum_bit(sbit16),
        .o_sum_valid(sval16), .o_done(done16), .o_result(res16), .o_cout(cout16),
        .o_ovf(ovf16)
    );

    serial_addsub #(.W(2)) u_dut2 (
        .i_clk(clk), .i_clear_n(clear_n), .i_start(start2), .i_mode(mode),
        .i_a(a[1:0]), .i_b(b[1:0]), .o_busy(busy2), .o_sum_bit(sbit2),
        .o_sum_valid(sval2), .o_done(done2), .o_result(res2), .o_cout(cout2), .o_ovf(ovf2)
    );

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    logic        o_busy, o_sbit, o_sval, o_done, o_cout, o_ovf;
    logic [15:0] o_res;

    always_comb begin
        o_busy = busy8; o_sbit = sbit8; o_sval = sval8; o_done = done8;
        o_cout = cout8; o_ovf = ovf8; o_res = {8'h00, res8};
        case (sel)
            1: begin
                o_busy = busy16; o_sbit = sbit16; o_sval = sval16; o_done = done16;
                o_cout = cout16; o_ovf = ovf16; o_res = res16;
            end
            2: begin
                o_busy = busy2; o_sbit = sbit2; o_sval = sval2; o_done = done2;
                o_cout = cout2; o_ovf = ovf2; o_res = {14'h0, res2};
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : (s == 2) ? 2 : 8;
    endfunction

    task automatic set_start(input logic v);
        case (sel)
            1:       start16 = v;
            2:       start2  = v;
            default: start8  = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_sum_bit"}, 32'(o_sbit), 0);
        check({tag, "_sum_valid"}, 32'(o_sval), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_result"}, 32'(o_res), 0);
        check({tag, "_cout"}, 32'(o_cout), 0);
        check({tag, "_ovf"}, 32'(o_ovf), 0);
    endtask

    // One operation: serial bits, exact done latency, final flags, then return to idle.
    task automatic run_op(input int s, input logic m, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er, input logic ec,
                          input logic eo, input string tag);
        int w;
        sel = s;
        w = width_of(s);
        mode = m; a = av; b = bv;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        // Operands changed mid-operation must not matter.
        a = ~av; b = ~bv; mode = ~m;
        check({tag, "_busy_e0"}, 32'(o_busy), 1);
        check({tag, "_valid_e0"}, 32'(o_sval), 0);
        for (int k = 0; k < w; k++) begin
            tick();
            check({tag, "_valid"}, 32'(o_sval), 1);
            check({tag, "_sum_bit"}, 32'(o_sbit), 32'(er[k]));
            if (k < w - 1) check({tag, "_early_done"}, 32'(o_done), 0);
        end
        check({tag, "_done"}, 32'(o_done), 1);
        check({tag, "_result"}, 32'(o_res), 32'(er));
        check({tag, "_cout"}, 32'(o_cout), 32'(ec));
        check({tag, "_ovf"}, 32'(o_ovf), 32'(eo));
        tick();
        check({tag, "_done_drop"}, 32'(o_done), 0);
        check({tag, "_valid_drop"}, 32'(o_sval), 0);
        check({tag, "_idle"}, 32'(o_busy), 0);
        check({tag, "_result_hold"}, 32'(o_res), 32'(er));
        check({tag, "_cout_hold"}, 32'(o_cout), 32'(ec));
        check({tag, "_ovf_hold"}, 32'(o_ovf), 32'(eo));
    endtask

    // Start held high: first done after W+1 edges, then every W+2.
    task automatic b2b(input int s, input string tag);
        int w, t, d1, d2;
        sel = s;
        w = width_of(s);
        mode = 1'b0; a = 16'd1; b = 16'd1;
        t = 0; d1 = -1; d2 = -1;
        set_start(1'b1);
        for (int i = 0; i < 200 && d2 < 0; i++) begin
            tick();
            t++;
            if (o_done) begin
                if (d1 < 0) d1 = t;
                else d2 = t;
            end
        end
        set_start(1'b0);
        check({tag, "_first_done"}, 32'(d1), 32'(w + 1));
        check({tag, "_spacing"}, 32'(d2 - d1), 32'(w + 2));
        for (int i = 0; i < w + 3; i++) tick();
        check({tag, "_settled"}, 32'(o_busy), 0);
    endtask

    initial begin
        int   dn;
        int   broke;
        logic [15:0] r;

        clear_n = 1'b0; mode = 1'b0; a = '0; b = '0;
        start8 = 1'b0; start16 = 1'b0; start2 = 1'b0;
        tick();
        tick();
        sel = 0;
        check_all_zero("reset");
        clear_n = 1'b1;

        run_op(0, 1'b0, 16'd3,   16'd7,  16'd10,  1'b0, 1'b0, "w8_add_3_7");
        run_op(0, 1'b0, 16'd255, 16'd255, 16'd254, 1'b1, 1'b0, "w8_add_255_255");
        run_op(0, 1'b0, 16'd100, 16'd97, 16'd197, 1'b0, 1'b1, "w8_add_100_97");
        run_op(0, 1'b1, 16'd5,   16'd7,  16'd254, 1'b0, 1'b0, "w8_sub_5_7");
        run_op(0, 1'b1, 16'd128, 16'd1,  16'd127, 1'b1, 1'b1, "w8_sub_128_1");

        run_op(1, 1'b0, 16'd3,   16'd7,  16'd10,  1'b0, 1'b0, "w16_add_3_7");
        run_op(1, 1'b0, 16'd255, 16'd255, 16'd510, 1'b0, 1'b0, "w16_add_255_255");
        run_op(1, 1'b0, 16'd100, 16'd97, 16'd197, 1'b0, 1'b0, "w16_add_100_97");

        run_op(2, 1'b0, 16'd3,   16'd1,  16'd0,   1'b1, 1'b0, "w2_add_3_1");

        // Start re-pulsed mid-run with new operands: must be ignored.
        sel = 0;
        mode = 1'b0; a = 16'd20; b = 16'd30;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        start8 = 1'b1; a = 16'd99; b = 16'd1; mode = 1'b1;
        tick();
        start8 = 1'b0;
        dn = 0; broke = 0; r = '0;
        if (!o_busy) broke = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_done) begin
                dn++;
                r = o_res;
            end
            if (dn == 0 && !o_busy) broke = 1;
        end
        check("ignore_start_done_count", 32'(dn), 1);
        check("ignore_start_result", 32'(r), 32'd50);
        check("ignore_start_busy_unbroken", 32'(broke), 0);

        // Clear in the middle of a run, with start asserted alongside.
        mode = 1'b0; a = 16'd9; b = 16'd9;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick(); tick();
        clear_n = 1'b0;
        start8  = 1'b1;
        tick();
        check_all_zero("midrun_clear");
        clear_n = 1'b1;
        start8  = 1'b0;
        broke = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_done || o_busy) broke = 1;
        end
        check("midrun_clear_no_done", 32'(broke), 0);
        run_op(0, 1'b0, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, "after_clear_1_1");

        b2b(0, "b2b_w8");
        b2b(1, "b2b_w16");
        b2b(2, "b2b_w2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
